change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 78 +++++++
 tb/tb_change_dispenser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out an amount in cents as one-hot coin pulses, largest coin first.
module change_dispenser #(
  parameter int WIDTH = 11,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             dollar_out,
  output logic             quarter_out,
  output logic             dime_out,
  output logic             nickel_out,
  output logic [WIDTH-1:0] remaining,
  output logic [4:0]       coin_count
);
  localparam int MAXC = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] coin, pick;
  logic [6:0] val;
  logic pulse_end, gap_end;
  assign pick = remaining >= WIDTH'(100) ? 4'b1000 :
                remaining >= WIDTH'(25)  ? 4'b0100 :
                remaining >= WIDTH'(10)  ? 4'b0010 :
                remaining >= WIDTH'(5)   ? 4'b0001 : 4'b0000;
  assign val = coin[3] ? 7'd100 : coin[2] ? 7'd25 : coin[1] ? 7'd10 : 7'd5;
  assign pulse_end = state == PULSE && cnt == CW'(PULSE_CYCLES - 1);
  assign gap_end = state == GAP && cnt == CW'(GAP_CYCLES - 1);
  assign busy = state == SELECT || state == PULSE || state == GAP;
  assign done = state == DONE;
  assign {dollar_out, quarter_out, dime_out, nickel_out} = coin;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SELECT : IDLE;
      SELECT:  state_n = pick != 4'b0000 ? PULSE : DONE;
      PULSE:   state_n = pulse_end ? GAP : PULSE;
      GAP:     state_n = gap_end ? SELECT : GAP;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Coin lines are registered: loaded in SELECT, cleared on the last PULSE edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      coin <= '0;
      short <= 1'b0;
      remaining <= '0;
      coin_count <= '0;
    end else begin
      cnt <= ((state == PULSE && !pulse_end) || (state == GAP && !gap_end)) ? cnt + CW'(1) : '0;
      if (state == IDLE && start) begin
        remaining <= amount;
        coin_count <= '0;
        short <= 1'b0;
      end
      if (state == SELECT) begin
        coin <= pick;
        if (pick == 4'b0000) short <= remaining != '0;
      end
      if (pulse_end) begin
        coin <= '0;
        remaining <= remaining - WIDTH'(val);
        coin_count <= coin_count + 5'd1;
      end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios for change_dispenser with hand-computed expectations.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [10:0] amount = '0;
  logic busy, done, short, dollar_out, quarter_out, dime_out, nickel_out;
  logic [10:0] remaining;
  logic [4:0] coin_count;
  int passed = 0;
  int total = 0;
  logic [3:0] seq[$];
  logic [15:0] seqp;
  int done_edge, multi, badlen, badgap;
  logic done_busy;
  change_dispenser dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .busy(busy), .done(done), .short(short),
    .dollar_out(dollar_out), .quarter_out(quarter_out),
    .dime_out(dime_out), .nickel_out(nickel_out),
    .remaining(remaining), .coin_count(coin_count)
  );
  always #5 clk = ~clk;
  task automatic kick(input logic [10:0] a);
    @(negedge clk);
    start = 1'b1;
    amount = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic run(input int budget, input int i1, input int i2);
    logic [3:0] cur, prev;
    int hi, lo;
    seq.delete();
    seqp = '0;
    multi = 0; badlen = 0; badgap = 0; hi = 0; lo = 0; prev = '0;
    done_edge = -1;
    done_busy = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cur = {dollar_out, quarter_out, dime_out, nickel_out};
      if ($countones(cur) > 1) multi++;
      if (cur != 0 && prev == 0) begin
        seq.push_back(cur);
        seqp = {seqp[11:0], cur};
        if (seq.size() > 1 && lo != 5) badgap++;
        hi = 0;
      end
      if (cur == 0 && prev != 0) begin
        if (hi != 4) badlen++;
        lo = 0;
      end
      if (cur != 0) hi++;
      else lo++;
      prev = cur;
      if (k == i1 || k == i2) begin
        start = 1'b1;
        amount = 11'd500;
      end
      if (done) begin
        done_edge = k;
        done_busy = busy;
        break;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, short} !== 3'b000) $display("FAIL reset_flags busy/done/short=%b want 000", {busy, done, short});
    else passed++;
    total++;
    if ({dollar_out, quarter_out, dime_out, nickel_out} !== 4'b0000) $display("FAIL reset_coins got %b want 0000", {dollar_out, quarter_out, dime_out, nickel_out});
    else passed++;
    total++;
    if (remaining !== 11'd0 || coin_count !== 5'd0) $display("FAIL reset_counts remaining=%0d coin_count=%0d want 0/0", remaining, coin_count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_140;
    kick(11'd140);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_rise_140 got %b want 1", busy);
    else passed++;
    run(100, -1, -1);
    total++;
    if (done_edge !== 37) $display("FAIL done_edge_140 got %0d want 37", done_edge);
    else passed++;
    total++;
    if (done_busy !== 1'b0) $display("FAIL done_busy_140 got %b want 0", done_busy);
    else passed++;
    total++;
    if (seq.size() !== 4 || seqp !== 16'h8421) $display("FAIL seq_140 got n=%0d %h want n=4 8421", seq.size(), seqp);
    else passed++;
    total++;
    if (badlen !== 0 || badgap !== 0) $display("FAIL shape_140 badlen=%0d badgap=%0d want 0/0", badlen, badgap);
    else passed++;
    total++;
    if (coin_count !== 5'd4 || remaining !== 11'd0 || short !== 1'b0) $display("FAIL end_140 count=%0d rem=%0d short=%b want 4/0/0", coin_count, remaining, short);
    else passed++;
  endtask
  task automatic test_zero;
    kick(11'd0);
    run(20, -1, -1);
    total++;
    if (done_edge !== 1) $display("FAIL done_edge_0 got %0d want 1", done_edge);
    else passed++;
    total++;
    if (seq.size() !== 0 || short !== 1'b0 || coin_count !== 5'd0) $display("FAIL end_0 n=%0d short=%b count=%0d want 0/0/0", seq.size(), short, coin_count);
    else passed++;
  endtask
  task automatic test_37;
    kick(11'd37);
    run(100, -1, -1);
    total++;
    if (done_edge !== 19) $display("FAIL done_edge_37 got %0d want 19", done_edge);
    else passed++;
    total++;
    if (seq.size() !== 2 || seqp[7:0] !== 8'h42) $display("FAIL seq_37 got n=%0d %h want n=2 42", seq.size(), seqp[7:0]);
    else passed++;
    total++;
    if (short !== 1'b1 || remaining !== 11'd2 || coin_count !== 5'd2) $display("FAIL end_37 short=%b rem=%0d count=%0d want 1/2/2", short, remaining, coin_count);
    else passed++;
  endtask
  task automatic test_2047;
    kick(11'd2047);
    run(400, -1, -1);
    total++;
    if (done_edge !== 208) $display("FAIL done_edge_2047 got %0d want 208", done_edge);
    else passed++;
    total++;
    if (seq.size() !== 23 || seq[0] !== 4'b1000 || seq[20] !== 4'b0100 || seq[22] !== 4'b0010) $display("FAIL seq_2047 n=%0d want 23 with dollar/quarter/dime at 0/20/22", seq.size());
    else passed++;
    total++;
    if (multi !== 0) $display("FAIL onehot_2047 multi-hot cycles=%0d want 0", multi);
    else passed++;
    total++;
    if (coin_count !== 5'd23 || remaining !== 11'd2 || short !== 1'b1) $display("FAIL end_2047 count=%0d rem=%0d short=%b want 23/2/1", coin_count, remaining, short);
    else passed++;
  endtask
  task automatic test_ignore_start;
    kick(11'd100);
    run(50, 3, 10);
    total++;
    if (done_edge !== 10 || seq.size() !== 1 || seqp[3:0] !== 4'b1000) $display("FAIL ignore_seq done_edge=%0d n=%0d want 10/1 dollar", done_edge, seq.size());
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || remaining !== 11'd0 || coin_count !== 5'd1) $display("FAIL ignore_end busy=%b rem=%0d count=%0d want 0/0/1", busy, remaining, coin_count);
    else passed++;
  endtask
  task automatic test_reset_mid;
    kick(11'd200);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dollar_out !== 1'b1) $display("FAIL mid_pulse dollar_out=%b want 1", dollar_out);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dollar_out, quarter_out, dime_out, nickel_out, busy} !== 5'b0) $display("FAIL mid_reset_lines got %b want 00000", {dollar_out, quarter_out, dime_out, nickel_out, busy});
    else passed++;
    total++;
    if (remaining !== 11'd0 || coin_count !== 5'd0) $display("FAIL mid_reset_counts rem=%0d count=%0d want 0/0", remaining, coin_count);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    kick(11'd5);
    run(50, -1, -1);
    total++;
    if (done_edge !== 10 || seq.size() !== 1 || seqp[3:0] !== 4'b0001) $display("FAIL after_reset_5 done_edge=%0d n=%0d want 10/1 nickel", done_edge, seq.size());
    else passed++;
    total++;
    if (coin_count !== 5'd1 || remaining !== 11'd0 || short !== 1'b0) $display("FAIL after_reset_end count=%0d rem=%0d short=%b want 1/0/0", coin_count, remaining, short);
    else passed++;
  endtask
  initial begin
    test_reset;
    test_140;
    test_zero;
    test_37;
    test_2047;
    test_ignore_start;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
